// File: rtl/regfile_pkg.sv
// Shared register-file constants for the write-back path: default widths,
// the hard-wired zero register and requester indices.
package regfile_pkg;

    localparam int AW_DEF = 5;
    localparam int DW_DEF = 32;
    localparam int GID_W  = 2;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam int REQ_ALU    = 0;
    localparam int REQ_LOAD   = 1;
    localparam int REQ_MULDIV = 2;

    // Next index after idx in a ring of n entries.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/regfile_wb_if.sv
// Write-back bus between the requesters (master side) and the register-file
// write-port arbiter (slave side).
interface regfile_wb_if #(
    parameter int NREQ = 3,
    parameter int AW   = 5,
    parameter int DW   = 32,
    parameter int CW   = 16
) ();

    logic                 hold;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 rf_we;
    logic [AW-1:0]        rf_wa;
    logic [DW-1:0]        rf_wd;
    logic [1:0]           grant_id;
    logic [CW-1:0]        contention_cnt;

    modport master (
        output hold, req_valid, req_addr, req_data,
        input  req_ready, rf_we, rf_wa, rf_wd, grant_id, contention_cnt
    );

    modport slave (
        input  hold, req_valid, req_addr, req_data,
        output req_ready, rf_we, rf_wa, rf_wd, grant_id, contention_cnt
    );

endinterface

// File: rtl/regfile_wb_arbiter_rr.sv
// Round-robin arbiter: searches from the pointer upward (wrapping) and grants
// the first active request; the pointer moves past each winner.
module rr_arbiter
    import regfile_pkg::*;
#(
    parameter int N  = 3,
    parameter int IW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_any
);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;
    int            scan_idx;

    // Priority search from ptr_q; no grant and a frozen pointer when disabled.
    always_comb begin
        gnt      = '0;
        gnt_idx  = '0;
        gnt_any  = 1'b0;
        ptr_d    = ptr_q;
        scan_idx = 0;
        if (en) begin
            for (int k = 0; k < N; k++) begin
                scan_idx = (int'(ptr_q) + k) % N;
                if (!gnt_any && req[scan_idx]) begin
                    gnt_any       = 1'b1;
                    gnt[scan_idx] = 1'b1;
                    gnt_idx       = IW'(scan_idx);
                    ptr_d         = IW'(wrap_inc(scan_idx, N));
                end else begin
                    gnt_any = gnt_any;
                end
            end
        end else begin
            gnt_any = 1'b0;
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: round-robin grant among write-back
// requesters, registered write port with r0 suppression, contention counter.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int NREQ = REQ_MULDIV + 1,
    parameter int AW   = AW_DEF,
    parameter int DW   = DW_DEF,
    parameter int CW   = 16
) (
    input  logic         clk,
    input  logic         reset,
    regfile_wb_if.slave  bus
);

    localparam int IW = GID_W;

    logic [NREQ-1:0] gnt_s;
    logic [IW-1:0]   gnt_idx_s;
    logic            gnt_any_s;
    logic            adv_en_s;
    logic [AW-1:0]   sel_addr_s;
    logic [DW-1:0]   sel_data_s;
    logic            multi_valid_s;
    int              valid_cnt_s;

    logic            rf_we_q, rf_we_d;
    logic [AW-1:0]   rf_wa_q, rf_wa_d;
    logic [DW-1:0]   rf_wd_q, rf_wd_d;
    logic [IW-1:0]   gid_q,   gid_d;
    logic [CW-1:0]   cnt_q,   cnt_d;

    assign adv_en_s = reset & ~bus.hold;

    rr_arbiter #(
        .N  (NREQ),
        .IW (IW)
    ) u_rr (
        .clk     (clk),
        .reset   (reset),
        .en      (adv_en_s),
        .req     (bus.req_valid),
        .gnt     (gnt_s),
        .gnt_idx (gnt_idx_s),
        .gnt_any (gnt_any_s)
    );

    // Winner's address/data and the "two or more requesters" contention flag.
    always_comb begin
        sel_addr_s  = bus.req_addr[int'(gnt_idx_s)*AW +: AW];
        sel_data_s  = bus.req_data[int'(gnt_idx_s)*DW +: DW];
        valid_cnt_s = 0;
        for (int i = 0; i < NREQ; i++) begin
            valid_cnt_s = valid_cnt_s + int'(bus.req_valid[i]);
        end
        multi_valid_s = (valid_cnt_s >= 2);
    end

    // Next write-port contents; r0 targets are accepted but never enabled.
    always_comb begin
        rf_we_d = 1'b0;
        rf_wa_d = rf_wa_q;
        rf_wd_d = rf_wd_q;
        gid_d   = gid_q;
        if (gnt_any_s) begin
            rf_we_d = (sel_addr_s != AW'(REG_ZERO));
            rf_wa_d = sel_addr_s;
            rf_wd_d = sel_data_s;
            gid_d   = gnt_idx_s;
        end else begin
            rf_we_d = 1'b0;
        end
    end

    // Saturating contention counter update.
    always_comb begin
        cnt_d = cnt_q;
        if (!bus.hold && multi_valid_s && (cnt_q != {CW{1'b1}})) begin
            cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Output register stage and counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rf_we_q <= 1'b0;
            rf_wa_q <= '0;
            rf_wd_q <= '0;
            gid_q   <= '0;
            cnt_q   <= '0;
        end else begin
            rf_we_q <= rf_we_d;
            rf_wa_q <= rf_wa_d;
            rf_wd_q <= rf_wd_d;
            gid_q   <= gid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.req_ready      = gnt_s;
    assign bus.rf_we          = rf_we_q;
    assign bus.rf_wa          = rf_wa_q;
    assign bus.rf_wd          = rf_wd_q;
    assign bus.grant_id       = gid_q;
    assign bus.contention_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vector table, randomized run against
// a queue-free reference model, and a 4-bit counter instance for saturation.
module tb_regfile_wb_arbiter;

    logic clk = 1'b0;
    logic reset;
    logic reset2;

    always #5 clk = ~clk;

    regfile_wb_if #(.NREQ(3), .AW(5), .DW(32), .CW(16)) bus  ();
    regfile_wb_if #(.NREQ(3), .AW(5), .DW(32), .CW(4))  bus2 ();

    regfile_wb_arbiter #(.NREQ(3), .AW(5), .DW(32), .CW(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    regfile_wb_arbiter #(.NREQ(3), .AW(5), .DW(32), .CW(4)) dut_sat (
        .clk   (clk),
        .reset (reset2),
        .bus   (bus2)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state: pointer, counter, and last write-port contents.
    int          m_ptr = 0;
    int          m_cnt = 0;
    bit          m_we  = 1'b0;
    logic [4:0]  m_wa  = 5'd0;
    logic [31:0] m_wd  = 32'd0;
    int          m_gid = 0;

    typedef struct {
        bit          rst;
        bit          hold;
        bit   [2:0]  valid;
        logic [14:0] a;
        logic [95:0] d;
        bit   [2:0]  ready;
        bit          we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [1:0]  gid;
        int          cnt;
    } vec_t;

    localparam logic [14:0] AD = {5'd3, 5'd2, 5'd1};
    localparam logic [95:0] DD = {32'h0000_0033, 32'h0000_0022, 32'h0000_0011};
    localparam logic [14:0] A8 = {5'd3, 5'd7, 5'd1};
    localparam logic [95:0] D8 = {32'h0000_0033, 32'hDEAD_BEEF, 32'h0000_0011};
    localparam logic [14:0] A9 = {5'd3, 5'd2, 5'd0};

    vec_t tv [20];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: actual %0h required %0h", nm, $time, act, exp);
        end
    endtask

    function automatic vec_t mk(input bit rst, input bit hold, input bit [2:0] v,
                                input logic [14:0] a, input logic [95:0] d,
                                input bit [2:0] r, input bit we, input logic [4:0] wa,
                                input logic [31:0] wd, input logic [1:0] gid, input int cnt);
        vec_t t;
        t.rst = rst; t.hold = hold; t.valid = v; t.a = a; t.d = d;
        t.ready = r; t.we = we; t.wa = wa; t.wd = wd; t.gid = gid; t.cnt = cnt;
        return t;
    endfunction

    // One clock of stimulus: predict from the model, check ready mid-cycle,
    // check the registered port after the edge. Called at posedge+1.
    task automatic drive_cycle(input bit rst, input bit hld, input bit [2:0] v,
                               input logic [14:0] a, input logic [95:0] d,
                               output int g, output logic [2:0] act_rdy);
        logic [2:0] exp_rdy;
        g = -1;
        if (rst && !hld) begin
            for (int k = 0; k < 3; k++) begin
                if (g < 0 && v[(m_ptr + k) % 3]) g = (m_ptr + k) % 3;
            end
        end
        exp_rdy = (g >= 0) ? (3'b001 << g) : 3'b000;
        reset         = rst;
        bus.hold      = hld;
        bus.req_valid = v;
        bus.req_addr  = a;
        bus.req_data  = d;
        @(negedge clk);
        act_rdy = bus.req_ready;
        chk("req_ready", act_rdy, exp_rdy);
        if (!rst) begin
            m_ptr = 0; m_cnt = 0; m_we = 1'b0; m_wa = 5'd0; m_wd = 32'd0; m_gid = 0;
        end else begin
            if (!hld && $countones(v) >= 2) m_cnt = (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
            if (g >= 0) begin
                m_wa  = a[g*5 +: 5];
                m_wd  = d[g*32 +: 32];
                m_gid = g;
                m_we  = (m_wa != 5'd0);
                m_ptr = (g + 1) % 3;
            end else begin
                m_we = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        chk("rf_we", bus.rf_we, m_we);
        if (!rst || g >= 0) begin
            chk("rf_wa", bus.rf_wa, m_wa);
            chk("rf_wd", bus.rf_wd, m_wd);
            chk("grant_id", bus.grant_id, m_gid);
        end
        chk("contention_cnt", bus.contention_cnt, m_cnt);
    endtask

    initial begin
        int          g;
        logic [2:0]  rdy;
        bit   [2:0]  pv;
        logic [14:0] pa;
        logic [95:0] pd;
        bit          rr;
        bit          hh;

        reset  = 1'b0;
        reset2 = 1'b0;
        bus.hold = 1'b0; bus.req_valid = 3'b000; bus.req_addr = '0; bus.req_data = '0;
        bus2.hold = 1'b0; bus2.req_valid = 3'b111; bus2.req_addr = AD; bus2.req_data = DD;

        tv[0]  = mk(1'b0, 1'b0, 3'b111, AD, DD, 3'b000, 1'b0, 5'd0, 32'h00, 2'd0, 0);
        tv[1]  = mk(1'b0, 1'b0, 3'b111, AD, DD, 3'b000, 1'b0, 5'd0, 32'h00, 2'd0, 0);
        tv[2]  = mk(1'b1, 1'b0, 3'b111, AD, DD, 3'b001, 1'b1, 5'd1, 32'h11, 2'd0, 1);
        tv[3]  = mk(1'b1, 1'b0, 3'b111, AD, DD, 3'b010, 1'b1, 5'd2, 32'h22, 2'd1, 2);
        tv[4]  = mk(1'b1, 1'b0, 3'b111, AD, DD, 3'b100, 1'b1, 5'd3, 32'h33, 2'd2, 3);
        tv[5]  = mk(1'b1, 1'b0, 3'b111, AD, DD, 3'b001, 1'b1, 5'd1, 32'h11, 2'd0, 4);
        tv[6]  = mk(1'b1, 1'b0, 3'b111, AD, DD, 3'b010, 1'b1, 5'd2, 32'h22, 2'd1, 5);
        tv[7]  = mk(1'b1, 1'b0, 3'b111, AD, DD, 3'b100, 1'b1, 5'd3, 32'h33, 2'd2, 6);
        tv[8]  = mk(1'b1, 1'b0, 3'b010, A8, D8, 3'b010, 1'b1, 5'd7, 32'hDEADBEEF, 2'd1, 6);
        tv[9]  = mk(1'b1, 1'b0, 3'b001, A9, DD, 3'b001, 1'b0, 5'd0, 32'h11, 2'd0, 6);
        tv[10] = mk(1'b1, 1'b0, 3'b011, AD, DD, 3'b010, 1'b1, 5'd2, 32'h22, 2'd1, 7);
        tv[11] = mk(1'b1, 1'b1, 3'b100, AD, DD, 3'b000, 1'b0, 5'd2, 32'h22, 2'd1, 7);
        tv[12] = mk(1'b1, 1'b1, 3'b100, AD, DD, 3'b000, 1'b0, 5'd2, 32'h22, 2'd1, 7);
        tv[13] = mk(1'b1, 1'b1, 3'b111, AD, DD, 3'b000, 1'b0, 5'd2, 32'h22, 2'd1, 7);
        tv[14] = mk(1'b1, 1'b0, 3'b100, AD, DD, 3'b100, 1'b1, 5'd3, 32'h33, 2'd2, 7);
        tv[15] = mk(1'b1, 1'b0, 3'b001, AD, DD, 3'b001, 1'b1, 5'd1, 32'h11, 2'd0, 7);
        tv[16] = mk(1'b0, 1'b0, 3'b111, AD, DD, 3'b000, 1'b0, 5'd0, 32'h00, 2'd0, 0);
        tv[17] = mk(1'b1, 1'b0, 3'b111, AD, DD, 3'b001, 1'b1, 5'd1, 32'h11, 2'd0, 1);
        tv[18] = mk(1'b1, 1'b0, 3'b100, AD, DD, 3'b100, 1'b1, 5'd3, 32'h33, 2'd2, 1);
        tv[19] = mk(1'b1, 1'b0, 3'b100, AD, DD, 3'b100, 1'b1, 5'd3, 32'h33, 2'd2, 1);

        @(posedge clk);
        #1;

        // Directed table: hand-derived expectations.
        for (int i = 0; i < 20; i++) begin
            drive_cycle(tv[i].rst, tv[i].hold, tv[i].valid, tv[i].a, tv[i].d, g, rdy);
            chk($sformatf("tv%0d.ready", i), rdy, tv[i].ready);
            chk($sformatf("tv%0d.we", i), bus.rf_we, tv[i].we);
            if (!tv[i].rst || tv[i].ready != 3'b000) begin
                chk($sformatf("tv%0d.wa", i), bus.rf_wa, tv[i].wa);
                chk($sformatf("tv%0d.wd", i), bus.rf_wd, tv[i].wd);
                chk($sformatf("tv%0d.gid", i), bus.grant_id, tv[i].gid);
            end
            chk($sformatf("tv%0d.cnt", i), bus.contention_cnt, tv[i].cnt);
        end

        // Randomized run; pending requests keep valid/addr/data until accepted.
        pv = 3'b000; pa = '0; pd = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (!pv[i] && $urandom_range(0, 2) != 0) begin
                    pv[i] = 1'b1;
                    pa[i*5 +: 5]   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
                    pd[i*32 +: 32] = $urandom;
                end
            end
            rr = ($urandom_range(0, 40) != 0);
            hh = ($urandom_range(0, 4) == 0);
            drive_cycle(rr, hh, pv, pa, pd, g, rdy);
            if (g >= 0) pv[g] = 1'b0;
        end

        // Saturation on the 4-bit counter instance, then reset while writing.
        reset2 = 1'b0;
        @(posedge clk);
        #1;
        chk("sat_reset_cnt", bus2.contention_cnt, 64'd0);
        reset2 = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("sat_cnt_%0d", k), bus2.contention_cnt, (k > 15) ? 64'd15 : 64'(k));
        end
        chk("sat_we_busy", bus2.rf_we, 64'd1);
        @(negedge clk);
        chk("sat_ptr_before", bus2.req_ready, 64'(3'b100));
        reset2 = 1'b0;
        @(negedge clk);
        chk("sat_ready_in_reset", bus2.req_ready, 64'd0);
        @(posedge clk);
        #1;
        chk("sat_we_after_rst", bus2.rf_we, 64'd0);
        chk("sat_cnt_after_rst", bus2.contention_cnt, 64'd0);
        chk("sat_gid_after_rst", bus2.grant_id, 64'd0);
        reset2 = 1'b1;
        @(negedge clk);
        chk("sat_ptr_after_rst", bus2.req_ready, 64'(3'b001));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
